// File: rtl/j_scan_controller.sv
// rtl/j_scan_controller.sv - raster-scan pixel request sequencer with row/frame completion and abort
// Optional macro J_SCAN_LINEAR_ADDR_EN adds a linear pixel address output.
module j_scan_controller #(
  parameter int DIM_W = 13
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DIM_W-1:0]   img_width,
  input  logic [DIM_W-1:0]   img_height,
`ifdef J_SCAN_LINEAR_ADDR_EN
  output logic [2*DIM_W-1:0] pix_addr,
`endif
  output logic               pix_req,
  input  logic               pix_ack,
  output logic [DIM_W-1:0]   col_idx,
  output logic [DIM_W-1:0]   row_idx,
  output logic               row_end,
  output logic               frame_done,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  state_t           state;
  logic [DIM_W-1:0] width_q;
  logic [DIM_W-1:0] height_q;
  logic             last_col;
  logic             last_row;

  // Indices never exceed dimension-1, so these compares cannot wrap.
  assign last_col = (col_idx == width_q - ONE);
  assign last_row = (row_idx == height_q - ONE);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      width_q    <= '0;
      height_q   <= '0;
      col_idx    <= '0;
      row_idx    <= '0;
      pix_req    <= 1'b0;
      row_end    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
`ifdef J_SCAN_LINEAR_ADDR_EN
      pix_addr   <= '0;
`endif
    end else begin
      row_end    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (img_width != '0 && img_height != '0) begin
              width_q  <= img_width;
              height_q <= img_height;
              col_idx  <= '0;
              row_idx  <= '0;
              pix_req  <= 1'b1;
              state    <= SCAN;
`ifdef J_SCAN_LINEAR_ADDR_EN
              pix_addr <= '0;
`endif
            end else begin
              frame_done <= 1'b1;
              state      <= DONE;
            end
          end
        end
        SCAN: begin
          if (abort) begin
            // Abort wins over a same-cycle ack: that pixel is not transferred.
            state   <= IDLE;
            busy    <= 1'b0;
            pix_req <= 1'b0;
            col_idx <= '0;
            row_idx <= '0;
`ifdef J_SCAN_LINEAR_ADDR_EN
            pix_addr <= '0;
`endif
          end else if (pix_ack) begin
`ifdef J_SCAN_LINEAR_ADDR_EN
            pix_addr <= pix_addr + 1'b1;
`endif
            if (last_col) begin
              col_idx <= '0;
              row_end <= 1'b1;
              if (last_row) begin
                row_idx    <= '0;
                pix_req    <= 1'b0;
                frame_done <= 1'b1;
                state      <= DONE;
`ifdef J_SCAN_LINEAR_ADDR_EN
                pix_addr   <= '0;
`endif
              end else begin
                row_idx <= row_idx + ONE;
              end
            end else begin
              col_idx <= col_idx + ONE;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          pix_req <= 1'b0;
          col_idx <= '0;
          row_idx <= '0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          pix_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_j_scan_controller.sv
// tb/tb_j_scan_controller.sv - scoreboard bench for j_scan_controller
// Covers J_SCAN_LINEAR_ADDR_EN when that macro is defined.
module tb_j_scan_controller;

  localparam int DIM_W = 13;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             pix_ack = 1'b0;
  logic [DIM_W-1:0] img_width = '0;
  logic [DIM_W-1:0] img_height = '0;
  logic             pix_req;
  logic [DIM_W-1:0] col_idx;
  logic [DIM_W-1:0] row_idx;
  logic             row_end;
  logic             frame_done;
  logic             busy;
`ifdef J_SCAN_LINEAR_ADDR_EN
  logic [2*DIM_W-1:0] pix_addr;
`endif

  j_scan_controller #(.DIM_W(DIM_W)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .start(start),
    .abort(abort),
    .img_width(img_width),
    .img_height(img_height),
`ifdef J_SCAN_LINEAR_ADDR_EN
    .pix_addr(pix_addr),
`endif
    .pix_req(pix_req),
    .pix_ack(pix_ack),
    .col_idx(col_idx),
    .row_idx(row_idx),
    .row_end(row_end),
    .frame_done(frame_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row;
  } pix_t;

  pix_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one frame from an IDLE negedge; returns handshakes, row_end and frame_done pulses,
  // and the cycle (1 = first cycle after the start edge) in which frame_done was seen.
  task automatic run_frame(input int w, input int h, input int stall_max, input int abort_at,
                           input bit poke, output int hs, output int rows, output int dones,
                           output int done_cyc);
    int   cyc = 0;
    int   stall;
    logic exp_re = 1'b0;
    logic exp_fd = 1'b0;
    logic waiting = 1'b0;
    logic [DIM_W-1:0] pc = '0;
    logic [DIM_W-1:0] pr = '0;
    pix_t e;
    hs = 0; rows = 0; dones = 0; done_cyc = -1;
    img_width = DIM_W'(w);
    img_height = DIM_W'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    img_width = 13'd5;
    img_height = 13'd7;
    if (w > 0 && h > 0) begin
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++)
          sb.push_back('{col: DIM_W'(c), row: DIM_W'(r)});
    end else begin
      exp_fd = 1'b1;
    end
    stall = $urandom_range(stall_max, 0);
    while (cyc < 20000) begin
      cyc++;
      check("row_end", row_end, exp_re);
      check("frame_done", frame_done, exp_fd);
      if (row_end) rows++;
      if (frame_done) begin dones++; done_cyc = cyc; end
      exp_re = 1'b0;
      exp_fd = 1'b0;
      if (!busy) break;
      if (w == 0 || h == 0) check("no_req", pix_req, 1'b0);
      if (waiting) begin
        check("hold_col", col_idx, pc);
        check("hold_row", row_idx, pr);
      end
      start = (poke && cyc == 3);
      pix_ack = 1'b0;
      waiting = 1'b0;
      if (pix_req) begin
        if (stall > 0) begin
          stall--;
          waiting = 1'b1;
          pc = col_idx;
          pr = row_idx;
        end else begin
          pix_ack = 1'b1;
          stall = $urandom_range(stall_max, 0);
          if (abort_at == hs + 1) begin
            abort = 1'b1;
          end else begin
            check("sb_nonempty", sb.size() != 0, 1'b1);
            e = sb.pop_front();
            check("col_idx", col_idx, e.col);
            check("row_idx", row_idx, e.row);
`ifdef J_SCAN_LINEAR_ADDR_EN
            check("pix_addr", pix_addr, hs);
`endif
            hs++;
            if (e.col == DIM_W'(w - 1)) begin
              exp_re = 1'b1;
              if (e.row == DIM_W'(h - 1)) exp_fd = 1'b1;
            end
          end
        end
      end
      @(negedge clk);
      abort = 1'b0;
      pix_ack = 1'b0;
      start = 1'b0;
    end
    if (cyc >= 20000) check("timeout", 1'b0, 1'b1);
    sb.delete();
  endtask

  int hs, rows, dones, dcyc;

  initial begin
    pix_ack = 1'b1;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_req", pix_req, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_idx", {col_idx, row_idx}, '0);
      check("rst_pulses", {row_end, frame_done}, 2'b00);
    end
    pix_ack = 1'b0;

    run_frame(3, 2, 0, 0, 1'b0, hs, rows, dones, dcyc);
    check("f3x2_hs", hs, 6);
    check("f3x2_rows", rows, 2);
    check("f3x2_dones", dones, 1);
    check("f3x2_done_cyc", dcyc, 7);

    run_frame(4, 4, 3, 0, 1'b0, hs, rows, dones, dcyc);
    check("f4x4_hs", hs, 16);
    check("f4x4_rows", rows, 4);
    check("f4x4_dones", dones, 1);

    run_frame(1, 1, 0, 0, 1'b0, hs, rows, dones, dcyc);
    check("f1x1_hs", hs, 1);
    check("f1x1_done_cyc", dcyc, 2);

    run_frame(0, 5, 0, 0, 1'b0, hs, rows, dones, dcyc);
    check("w0_hs", hs, 0);
    check("w0_dones", dones, 1);
    check("w0_done_cyc", dcyc, 1);

    run_frame(5, 0, 0, 0, 1'b0, hs, rows, dones, dcyc);
    check("h0_dones", dones, 1);

    run_frame(8191, 1, 0, 0, 1'b0, hs, rows, dones, dcyc);
    check("wmax_hs", hs, 8191);
    check("wmax_rows", rows, 1);
    check("wmax_dones", dones, 1);

    run_frame(10, 10, 1, 38, 1'b0, hs, rows, dones, dcyc);
    check("abort_hs", hs, 37);
    check("abort_dones", dones, 0);
    check("abort_rows", rows, 3);
    check("abort_req", pix_req, 1'b0);
    check("abort_idx", {col_idx, row_idx}, '0);

    run_frame(2, 3, 1, 0, 1'b1, hs, rows, dones, dcyc);
    check("poke_hs", hs, 6);
    check("poke_rows", rows, 3);
    check("poke_dones", dones, 1);

    img_width = 13'd10;
    img_height = 13'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pix_ack = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_busy_pre", busy, 1'b1);
    n_rst = 1'b0;
    @(negedge clk);
    check("mrst_req", pix_req, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_idx", {col_idx, row_idx}, '0);
    check("mrst_pulses", {row_end, frame_done}, 2'b00);
    n_rst = 1'b1;
    pix_ack = 1'b0;
    @(negedge clk);

    run_frame(4, 3, 0, 0, 1'b0, hs, rows, dones, dcyc);
    check("f4x3_hs", hs, 12);
    check("f4x3_dones", dones, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
